// File: rtl/e1_rx_bd_ctrl.sv
// e1_rx_bd_ctrl: submit/completion descriptor queues between the host and the E1 receiver
module e1_rx_bd_ctrl #(
  parameter int MFW = 7,
  parameter int DW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_enable,
  input  logic ctrl_flush,
  input  logic [MFW-1:0] sub_mf,
  input  logic sub_valid,
  output logic sub_ready,
  output logic [DW:0] sub_level,
  output logic [MFW-1:0] bd_mf,
  output logic bd_valid,
  input  logic [1:0] bd_crc_e,
  input  logic bd_done,
  input  logic bd_miss,
  output logic [MFW-1:0] cpl_mf,
  output logic [1:0] cpl_crc_e,
  output logic cpl_valid,
  input  logic cpl_ack,
  output logic [DW:0] cpl_level,
  output logic [15:0] stat_miss_cnt,
  output logic stat_ovf,
  output logic stat_spurious,
  input  logic stat_clr
);
  localparam int depth = 1 << DW;
  localparam logic [DW:0] full = (DW+1)'(depth);
  logic [MFW-1:0] sub_mem [depth];
  logic [MFW+1:0] cpl_mem [depth];
  logic [DW-1:0] sub_wp, sub_rp, cpl_wp, cpl_rp;
  logic [DW:0] sub_cnt, cpl_cnt;
  logic sub_push, sub_pop, cpl_push, cpl_pop;
  assign sub_ready = sub_cnt != full;
  assign sub_level = sub_cnt;
  assign bd_valid = ctrl_enable & (sub_cnt != '0);
  assign bd_mf = sub_mem[sub_rp];
  assign cpl_valid = cpl_cnt != '0;
  assign cpl_level = cpl_cnt;
  assign {cpl_crc_e, cpl_mf} = cpl_mem[cpl_rp];
  assign sub_push = sub_valid & sub_ready & ~ctrl_flush;
  assign sub_pop = bd_done & (sub_cnt != '0);
  assign cpl_pop = cpl_ack & cpl_valid;
  // a full completion queue still accepts the record when the host frees a slot this cycle
  assign cpl_push = sub_pop & ((cpl_cnt != full) | cpl_pop);
  // submit queue; flush discards everything including a same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_wp <= '0;
      sub_rp <= '0;
      sub_cnt <= '0;
      for (int i = 0; i < depth; i++) sub_mem[i] <= '0;
    end else begin
      if (sub_push) sub_mem[sub_wp] <= sub_mf;
      if (ctrl_flush) begin
        sub_wp <= '0;
        sub_rp <= '0;
        sub_cnt <= '0;
      end else begin
        sub_wp <= sub_wp + DW'(sub_push);
        sub_rp <= sub_rp + DW'(sub_pop);
        sub_cnt <= sub_cnt + (DW+1)'(sub_push) - (DW+1)'(sub_pop);
      end
    end
  end
  // completion queue holding {crc, index} records for the host
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpl_wp <= '0;
      cpl_rp <= '0;
      cpl_cnt <= '0;
      for (int i = 0; i < depth; i++) cpl_mem[i] <= '0;
    end else begin
      if (cpl_push) cpl_mem[cpl_wp] <= {bd_crc_e, sub_mem[sub_rp]};
      cpl_wp <= cpl_wp + DW'(cpl_push);
      cpl_rp <= cpl_rp + DW'(cpl_pop);
      cpl_cnt <= cpl_cnt + (DW+1)'(cpl_push) - (DW+1)'(cpl_pop);
    end
  end
  // statistics; clear wins over any same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_miss_cnt <= '0;
      stat_ovf <= 1'b0;
      stat_spurious <= 1'b0;
    end else if (stat_clr) begin
      stat_miss_cnt <= '0;
      stat_ovf <= 1'b0;
      stat_spurious <= 1'b0;
    end else begin
      stat_miss_cnt <= stat_miss_cnt + 16'(bd_miss & (stat_miss_cnt != 16'hFFFF));
      stat_ovf <= stat_ovf | (sub_pop & ~cpl_push);
      stat_spurious <= stat_spurious | (bd_done & (sub_cnt == '0));
    end
  end
endmodule

// File: tb/tb_e1_rx_bd_ctrl.sv
// tb_e1_rx_bd_ctrl: randomized and directed scoreboard bench for e1_rx_bd_ctrl
module tb_e1_rx_bd_ctrl;
  logic clk = 0, rst = 1;
  logic ctrl_enable = 1, ctrl_flush = 0, sub_valid = 0, bd_done = 0, bd_miss = 0, cpl_ack = 0, stat_clr = 0;
  logic [6:0] sub_mf = 0, bd_mf, cpl_mf;
  logic [1:0] bd_crc_e = 0, cpl_crc_e;
  logic sub_ready, bd_valid, cpl_valid, stat_ovf, stat_spurious;
  logic [2:0] sub_level, cpl_level;
  logic [15:0] stat_miss_cnt;
  int n_chk = 0, n_pass = 0;
  int sq[$];
  logic [8:0] exp_cpl[$];
  int m_cpl = 0, m_miss = 0;
  bit m_ovf = 0, m_spur = 0;

  e1_rx_bd_ctrl #(.MFW(7), .DW(2)) dut (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .ctrl_flush(ctrl_flush),
    .sub_mf(sub_mf), .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_level(sub_level),
    .bd_mf(bd_mf), .bd_valid(bd_valid), .bd_crc_e(bd_crc_e), .bd_done(bd_done), .bd_miss(bd_miss),
    .cpl_mf(cpl_mf), .cpl_crc_e(cpl_crc_e), .cpl_valid(cpl_valid), .cpl_ack(cpl_ack),
    .cpl_level(cpl_level), .stat_miss_cnt(stat_miss_cnt), .stat_ovf(stat_ovf),
    .stat_spurious(stat_spurious), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // monitor: whenever the host pops a completion, it must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && cpl_valid && cpl_ack) begin
      if (exp_cpl.size() == 0) chk("cpl_unexpected", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_cpl.pop_front();
        chk("cpl_mf", cpl_mf, e[6:0]);
        chk("cpl_crc_e", cpl_crc_e, e[8:7]);
      end
    end
  end

  task automatic model_reset();
    sq.delete();
    exp_cpl.delete();
    m_cpl = 0;
    m_miss = 0;
    m_ovf = 0;
    m_spur = 0;
  endtask

  task automatic check_state();
    chk("sub_level", sub_level, sq.size());
    chk("sub_ready", sub_ready, sq.size() < 4);
    chk("bd_valid", bd_valid, ctrl_enable && sq.size() > 0);
    if (sq.size() > 0) chk("bd_mf", bd_mf, sq[0]);
    chk("cpl_level", cpl_level, m_cpl);
    chk("cpl_valid", cpl_valid, m_cpl > 0);
    chk("stat_miss_cnt", stat_miss_cnt, m_miss);
    chk("stat_ovf", stat_ovf, m_ovf);
    chk("stat_spurious", stat_spurious, m_spur);
  endtask

  // one clock: apply the behavioural rules to the inputs held over the edge, then compare
  task automatic step();
    int n, h;
    bit ack_ok, ovf_ev;
    @(posedge clk);
    #1;
    n = sq.size();
    ack_ok = cpl_ack && m_cpl > 0;
    ovf_ev = 0;
    if (ack_ok) m_cpl--;
    if (bd_done && n > 0) begin
      h = sq.pop_front();
      if (m_cpl < 4) begin
        exp_cpl.push_back({bd_crc_e, 7'(h)});
        m_cpl++;
      end else ovf_ev = 1;
    end
    if (sub_valid && n < 4 && !ctrl_flush) sq.push_back(int'(sub_mf));
    if (ctrl_flush) sq.delete();
    if (stat_clr) begin
      m_miss = 0;
      m_ovf = 0;
      m_spur = 0;
    end else begin
      if (bd_miss && m_miss < 65535) m_miss++;
      if (ovf_ev) m_ovf = 1;
      if (bd_done && n == 0) m_spur = 1;
    end
    check_state();
    {ctrl_flush, sub_valid, bd_done, bd_miss, cpl_ack, stat_clr} = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    chk("rst_bd_mf", bd_mf, 0);
    chk("rst_cpl_mf", cpl_mf, 0);
    check_state();
    // push 3 then 5; head appears one cycle after the first push
    sub_valid = 1; sub_mf = 3; step();
    chk("first_head", bd_mf, 3);
    sub_valid = 1; sub_mf = 5; step();
    step();
    // complete head with CRC status 2'b10, then acknowledge it
    bd_done = 1; bd_crc_e = 2'b10; step();
    chk("second_head", bd_mf, 5);
    chk("cpl_first", cpl_mf, 3);
    cpl_ack = 1; step();
    // drain, then fill submit queue and try a 5th push, then done + push together
    bd_done = 1; step();
    cpl_ack = 1; step();
    for (int i = 0; i < 5; i++) begin sub_valid = 1; sub_mf = 7'(10 + i); step(); end
    sub_valid = 1; sub_mf = 99; bd_done = 1; step();
    chk("full_pop_level", sub_level, 3);
    // overflow the completion queue, then overflow avoided by a same-cycle ack
    for (int i = 0; i < 6; i++) begin sub_valid = 1; sub_mf = 7'(40 + i); bd_done = 1; step(); end
    chk("ovf_seen", stat_ovf, 1);
    stat_clr = 1; step();
    sub_valid = 1; sub_mf = 77; bd_done = 1; cpl_ack = 1; step();
    for (int i = 0; i < 4; i++) begin cpl_ack = 1; step(); end
    // spurious completion, saturating miss counter, then clear
    ctrl_flush = 1; step();
    bd_done = 1; step();
    for (int i = 0; i < 70000; i++) begin bd_miss = 1; step(); end
    chk("miss_sat", stat_miss_cnt, 16'hFFFF);
    stat_clr = 1; bd_miss = 1; step();
    // disable hides the head; flush beats a same-cycle push
    sub_valid = 1; sub_mf = 21; step();
    sub_valid = 1; sub_mf = 22; step();
    ctrl_enable = 0; step();
    chk("dis_bd_mf", bd_mf, 21);
    bd_done = 1; bd_crc_e = 2'b01; step();
    ctrl_enable = 1; ctrl_flush = 1; sub_valid = 1; sub_mf = 23; step();
    cpl_ack = 1; step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ctrl_enable = $urandom_range(0, 9) != 0;
      ctrl_flush = $urandom_range(0, 40) == 0;
      sub_valid = $urandom_range(0, 1) == 1;
      sub_mf = 7'($urandom);
      bd_done = $urandom_range(0, 2) == 0;
      bd_crc_e = 2'($urandom);
      bd_miss = $urandom_range(0, 7) == 0;
      cpl_ack = $urandom_range(0, 3) == 0;
      stat_clr = $urandom_range(0, 60) == 0;
      step();
    end
    // asynchronous reset in the middle of activity
    ctrl_enable = 1;
    sub_valid = 1; sub_mf = 9; bd_miss = 1; step();
    bd_done = 1; step();
    #2 rst = 1;
    #1;
    chk("arst_sub_level", sub_level, 0);
    chk("arst_sub_ready", sub_ready, 1);
    chk("arst_bd_valid", bd_valid, 0);
    chk("arst_bd_mf", bd_mf, 0);
    chk("arst_cpl_valid", cpl_valid, 0);
    chk("arst_cpl_level", cpl_level, 0);
    chk("arst_cpl_mf", cpl_mf, 0);
    chk("arst_cpl_crc_e", cpl_crc_e, 0);
    chk("arst_miss", stat_miss_cnt, 0);
    chk("arst_ovf", stat_ovf, 0);
    chk("arst_spur", stat_spurious, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
